// File: rtl/memory_responder.sv
// Word-organised memory target with a programmable wait count and a one-cycle ready pulse.
// Optional misaligned-access checking is enabled by defining MEMORY_RESPONDER_FAULT_EN.
//
// state     | meaning
// ----------+-------------------------------------------
// S_IDLE    | no access outstanding
// S_WAIT    | wait-count running on a captured request
// S_RESPOND | ready high for exactly this cycle
module memory_responder #(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        misaligned_fault
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           write_q, write_d;
    logic           misal_q, misal_d;
    logic [31:0]    read_data_q, read_data_d;

    logic [31:0]    ram [MEM_DEPTH];

    logic           req;
    logic           req_misal;
    logic           commit;
    logic           commit_wr;
    logic           commit_misal;
    logic [AW-1:0]  commit_addr;
    logic [31:0]    commit_data;
    logic           ram_we;
    logic           unused_addr;

    assign req = memory_read | memory_write;

`ifdef MEMORY_RESPONDER_FAULT_EN
    assign req_misal = (address[1:0] != 2'b00);
`else
    assign req_misal = 1'b0;
`endif

    assign unused_addr = ^{address[31:AW+2], address[1:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        misal_d      = misal_q;
        commit       = 1'b0;
        commit_wr    = write_q;
        commit_misal = misal_q;
        commit_addr  = addr_q;
        commit_data  = wdata_q;

        case (state_q)
            S_IDLE, S_RESPOND: begin
                if (req) begin
                    addr_d  = address[AW+1:2];
                    wdata_d = write_data;
                    write_d = memory_write;
                    misal_d = req_misal;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        // zero wait: the acceptance edge is also the completion edge
                        state_d      = S_RESPOND;
                        commit       = 1'b1;
                        commit_wr    = memory_write;
                        commit_misal = req_misal;
                        commit_addr  = address[AW+1:2];
                        commit_data  = write_data;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESPOND;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ram_we      = commit & commit_wr & ~commit_misal;
        read_data_d = read_data_q;
        if (commit & ~commit_wr & ~commit_misal) begin
            read_data_d = ram[commit_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            write_q     <= 1'b0;
            misal_q     <= 1'b0;
            read_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            misal_q     <= misal_d;
            read_data_q <= read_data_d;
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[commit_addr] <= commit_data;
        end
    end

    assign read_data = read_data_q;
    assign ready     = (state_q == S_RESPOND);

`ifdef MEMORY_RESPONDER_FAULT_EN
    assign misaligned_fault = ready & misal_q;
`else
    assign misaligned_fault = 1'b0;
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (0, 3 and 4 wait states) driven from a vector table,
// with expected completions queued at drive time and checked when ready appears.
module tb_memory_responder;

`ifdef MEMORY_RESPONDER_FAULT_EN
    localparam bit FLT = 1'b1;
`else
    localparam bit FLT = 1'b0;
`endif

    localparam int NV = 20;

    typedef struct {
        int          inst;
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        b2b;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        int          inst;
        int          exp_cyc;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_a    [3];
    logic        wr_a    [3];
    logic [31:0] addr_a  [3];
    logic [31:0] wdata_a [3];
    logic [31:0] rdata_a [3];
    logic        rdy_a   [3];
    logic        flt_a   [3];

    int   cyc = 0;
    int   checks = 0;
    int   n_err = 0;
    int   last_exp = 0;
    sb_t  sb [$];
    sb_t  mon_e;
    vec_t vecs [NV];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_responder #(.MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .memory_read(rd_a[0]), .memory_write(wr_a[0]),
        .address(addr_a[0]), .write_data(wdata_a[0]), .read_data(rdata_a[0]),
        .ready(rdy_a[0]), .misaligned_fault(flt_a[0]));

    memory_responder #(.MEM_DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .memory_read(rd_a[1]), .memory_write(wr_a[1]),
        .address(addr_a[1]), .write_data(wdata_a[1]), .read_data(rdata_a[1]),
        .ready(rdy_a[1]), .misaligned_fault(flt_a[1]));

    memory_responder #(.MEM_DEPTH(1024), .WAIT_STATES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .memory_read(rd_a[2]), .memory_write(wr_a[2]),
        .address(addr_a[2]), .write_data(wdata_a[2]), .read_data(rdata_a[2]),
        .ready(rdy_a[2]), .misaligned_fault(flt_a[2]));

    function automatic int ws_of(input int k);
        case (k)
            0:       return 0;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        for (int k = 0; k < 3; k++) begin
            rd_a[k] = 1'b0;
            wr_a[k] = 1'b0;
        end
    endtask

    task automatic drive(input vec_t v);
        sb_t e;
        rd_a[v.inst]    = v.rd;
        wr_a[v.inst]    = v.wr;
        addr_a[v.inst]  = v.addr;
        wdata_a[v.inst] = v.wdata;
        e.inst      = v.inst;
        e.exp_cyc   = cyc + 1 + ws_of(v.inst);
        e.exp_rdata = v.exp_rdata;
        e.exp_fault = v.exp_fault;
        sb.push_back(e);
        last_exp = e.exp_cyc;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
        step();
    endtask

    // completion monitor: every ready pulse must match the oldest queued expectation
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rdy_a[k] === 1'b1) begin
                checks++;
                if (sb.size() == 0 || sb[0].inst != k) begin
                    n_err++;
                    $display("FAIL unexpected_ready inst=%0d cyc=%0d", k, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (cyc != mon_e.exp_cyc) begin
                        n_err++;
                        $display("FAIL ready_cycle inst=%0d got=%0d required=%0d", k, cyc, mon_e.exp_cyc);
                    end
                    checks++;
                    if (rdata_a[k] !== mon_e.exp_rdata) begin
                        n_err++;
                        $display("FAIL read_data inst=%0d got=%h required=%h", k, rdata_a[k], mon_e.exp_rdata);
                    end
                    checks++;
                    if (flt_a[k] !== mon_e.exp_fault) begin
                        n_err++;
                        $display("FAIL misaligned_fault inst=%0d got=%b required=%b", k, flt_a[k], mon_e.exp_fault);
                    end
                end
            end
            if (flt_a[k] === 1'b1 && rdy_a[k] !== 1'b1) begin
                checks++;
                n_err++;
                $display("FAIL fault_without_ready inst=%0d cyc=%0d", k, cyc);
            end
        end
    end

    initial begin
        //          inst wr    rd    addr          wdata         b2b   exp_rdata                      exp_fault
        vecs[0]  = '{0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000,                 1'b0};
        vecs[1]  = '{0, 1'b0, 1'b1, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF,                 1'b0};
        vecs[2]  = '{0, 1'b1, 1'b0, 32'h0000_0020, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF,                 1'b0};
        vecs[3]  = '{0, 1'b0, 1'b1, 32'h0000_0020, 32'h0,         1'b1, 32'hA5A5_A5A5,                 1'b0};
        vecs[4]  = '{0, 1'b1, 1'b1, 32'h0000_0024, 32'h0000_0005, 1'b0, 32'hA5A5_A5A5,                 1'b0};
        vecs[5]  = '{0, 1'b0, 1'b1, 32'h0000_0024, 32'h0,         1'b0, 32'h0000_0005,                 1'b0};
        vecs[6]  = '{0, 1'b1, 1'b0, 32'h0000_0030, 32'h0000_1234, 1'b0, 32'h0000_0005,                 1'b0};
        vecs[7]  = '{0, 1'b1, 1'b0, 32'h0000_0032, 32'h0000_0099, 1'b0, 32'h0000_0005,                 FLT};
        vecs[8]  = '{0, 1'b0, 1'b1, 32'h0000_0030, 32'h0,         1'b0, FLT ? 32'h1234 : 32'h99,      1'b0};
        vecs[9]  = '{0, 1'b0, 1'b1, 32'h0000_0033, 32'h0,         1'b0, FLT ? 32'h1234 : 32'h99,      FLT};
        vecs[10] = '{1, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000,                 1'b0};
        vecs[11] = '{1, 1'b0, 1'b1, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF,                 1'b0};
        vecs[12] = '{1, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0001, 1'b0, 32'hDEAD_BEEF,                 1'b0};
        vecs[13] = '{1, 1'b0, 1'b1, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0001,                 1'b0};
        vecs[14] = '{1, 1'b1, 1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0000_0001,                 1'b0};
        vecs[15] = '{1, 1'b0, 1'b1, 32'h0000_1FFC, 32'h0,         1'b0, 32'hCAFE_F00D,                 1'b0};
        vecs[16] = '{1, 1'b1, 1'b0, 32'h0000_0040, 32'hBEEF_0001, 1'b0, 32'hCAFE_F00D,                 1'b0};
        vecs[17] = '{1, 1'b0, 1'b1, 32'h0000_0040, 32'h0,         1'b1, 32'hBEEF_0001,                 1'b0};
        vecs[18] = '{2, 1'b1, 1'b0, 32'h0000_0030, 32'h0000_0011, 1'b0, 32'h0000_0000,                 1'b0};
        vecs[19] = '{2, 1'b0, 1'b1, 32'h0000_0030, 32'h0,         1'b0, 32'h0000_0011,                 1'b0};

        for (int k = 0; k < 3; k++) begin
            addr_a[k]  = 32'd0;
            wdata_a[k] = 32'd0;
        end
        clear();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        repeat (10) begin
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rdy_a[k] !== 1'b0 || rdata_a[k] !== 32'd0) begin
                    n_err++;
                    $display("FAIL reset_idle inst=%0d ready=%b read_data=%h required 0/0", k, rdy_a[k], rdata_a[k]);
                end
            end
        end

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            if (i + 1 < NV && vecs[i+1].b2b) begin
                step();
                if (cyc < last_exp) begin
                    clear();
                    while (cyc < last_exp) step();
                end
            end else begin
                step();
                clear();
                wait_drain();
            end
        end

        // reset during WAIT drops the captured write to 0x30; the earlier 0x11 stays
        wr_a[2]    = 1'b1;
        addr_a[2]  = 32'h30;
        wdata_a[2] = 32'h77;
        step();
        clear();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdy_a[2] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async_ready got=%b required=0", rdy_a[2]);
        end
        repeat (3) begin
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rdy_a[k] !== 1'b0) begin
                    n_err++;
                    $display("FAIL ready_in_reset inst=%0d got=%b required=0", k, rdy_a[k]);
                end
            end
            checks++;
            if (rdata_a[2] !== 32'd0) begin
                n_err++;
                $display("FAIL read_data_in_reset got=%h required=0", rdata_a[2]);
            end
        end
        rst_n = 1'b1;
        step();
        drive('{2, 1'b0, 1'b1, 32'h30, 32'h0, 1'b0, 32'h0000_0011, 1'b0});
        step();
        clear();
        wait_drain();
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, n_err);
        $finish;
    end

endmodule
